// File: rtl/lane_enc_pkg.sv
// Shared constants and block type for the 64b/66b lane block encoder.
package lane_enc_pkg;

    localparam int unsigned BYTES_PER_BLOCK = 8;
    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned PAYLOAD_W       = 64;
    localparam int unsigned BLOCK_W         = 66;
    localparam int unsigned IDX_W           = 3;
    localparam int unsigned LFSR_W          = 23;

    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_OS   = 2'b01;

    // x^23+x^21+x^16+x^8+x^5+x^2+1, exponent k mapped to state bit k-1
    localparam logic [LFSR_W-1:0] LFSR_TAPS  = 23'h508092;
    localparam logic [LFSR_W-1:0] LANE0_SEED = 23'h1DBFBC;
    localparam logic [LFSR_W-1:0] LANE1_SEED = 23'h0607BB;

    typedef struct packed {
        logic [PAYLOAD_W-1:0] payload;
        logic [1:0]           sync;
    } lane_block_t;

endpackage

// File: rtl/lane_block_packer.sv
// Per-lane byte slotting into a 64-bit payload and registered block output.
// Optional payload scrambler enabled by LANE_BLOCK_SCRAMBLE_EN.
module lane_block_packer
    import lane_enc_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = LANE0_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              accept,
    input  logic              reload,
    input  logic [IDX_W-1:0]  idx,
    input  logic [BYTE_W-1:0] data,
    input  logic [1:0]        sync,
    output lane_block_t       block
);

    logic [PAYLOAD_W-1:0] payload;
    logic [PAYLOAD_W-1:0] payload_nx;
    logic [BYTE_W-1:0]    data_s;

`ifdef LANE_BLOCK_SCRAMBLE_EN
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] lfsr_nx;

    // LSB first: each bit uses the current MSB, then the register steps once
    always_comb begin
        lfsr_nx = lfsr;
        data_s  = data;
        for (int i = 0; i < BYTE_W; i++) begin
            data_s[i] = data[i] ^ lfsr_nx[LFSR_W-1];
            lfsr_nx   = {lfsr_nx[LFSR_W-2:0], ^(lfsr_nx & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || reload) begin
            lfsr <= SEED;
        end else if (accept) begin
            lfsr <= lfsr_nx;
        end
    end
`else
    logic unused_scr;
    assign unused_scr = &{1'b0, reload, SEED};
    assign data_s     = data;
`endif

    // Slot 0 starts a fresh payload
    always_comb begin
        payload_nx = (idx == '0) ? '0 : payload;
        payload_nx[{idx, 3'b000} +: BYTE_W] = data_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            payload <= '0;
            block   <= '0;
        end else if (accept) begin
            payload <= payload_nx;
            if (idx == IDX_W'(BYTES_PER_BLOCK - 1)) begin
                block <= '{payload: payload_nx, sync: sync};
            end
        end
    end

endmodule

// File: rtl/lane_block_encoder.sv
// Two-lane 64b/66b block encoder: shared byte counter, type latch, valid and error strobes.
// Build with LANE_BLOCK_SCRAMBLE_EN to scramble the payload per lane.
module lane_block_encoder
    import lane_enc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_enc,
    input  logic              data_os,
    input  logic [BYTE_W-1:0] lane_0_in,
    input  logic [BYTE_W-1:0] lane_1_in,
    output lane_block_t       lane_0_block,
    output lane_block_t       lane_1_block,
    output logic              block_valid,
    output logic              os_mix_err
);

    logic [IDX_W-1:0] byte_idx;
    logic             blk_type;
    logic             low_prev;
    logic             drop;
    logic [1:0]       sync;

    assign drop = !enable_enc && low_prev;
    assign sync = blk_type ? SYNC_DATA : SYNC_OS;

    // A second consecutive idle cycle abandons the partial block
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx    <= '0;
            blk_type    <= 1'b0;
            low_prev    <= 1'b0;
            block_valid <= 1'b0;
            os_mix_err  <= 1'b0;
        end else begin
            block_valid <= 1'b0;
            os_mix_err  <= 1'b0;
            if (enable_enc) begin
                low_prev <= 1'b0;
                byte_idx <= byte_idx + IDX_W'(1);
                if (byte_idx == '0) begin
                    blk_type <= data_os;
                end else if (data_os != blk_type) begin
                    os_mix_err <= 1'b1;
                end
                if (byte_idx == IDX_W'(BYTES_PER_BLOCK - 1)) begin
                    block_valid <= 1'b1;
                end
            end else begin
                low_prev <= 1'b1;
                if (low_prev) begin
                    byte_idx <= '0;
                end
            end
        end
    end

    lane_block_packer #(.SEED(LANE0_SEED)) u_lane_0 (
        .clk    (clk),
        .rst    (rst),
        .accept (enable_enc),
        .reload (drop),
        .idx    (byte_idx),
        .data   (lane_0_in),
        .sync   (sync),
        .block  (lane_0_block)
    );

    lane_block_packer #(.SEED(LANE1_SEED)) u_lane_1 (
        .clk    (clk),
        .rst    (rst),
        .accept (enable_enc),
        .reload (drop),
        .idx    (byte_idx),
        .data   (lane_1_in),
        .sync   (sync),
        .block  (lane_1_block)
    );

endmodule
